truth_table_sequencer: RTL

// - Self-test controller for a 3-input/2-output combinational block (inputs a,b,c; outputs x,y).
// - On start: drives all 8 input combinations in order, waits a settle time, and compares x/y

---
 rtl/truth_table_sequencer_if.sv | 38 +++
 rtl/truth_table_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/truth_table_sequencer_if.sv
// Signal bundle between the truth-table self-test sequencer and the host / block under test.
// Optional TT_FAIL_LOG_EN adds the first-failure log signals fail_valid and fail_vec.
`timescale 1ns/1ps
interface truth_table_sequencer_if;
  logic       start;
  logic       dut_x;
  logic       dut_y;
  logic       dut_a;
  logic       dut_b;
  logic       dut_c;
  logic [2:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
`ifdef TT_FAIL_LOG_EN
  logic       fail_valid;
  logic [2:0] fail_vec;

  modport master (
    output start, dut_x, dut_y,
    input  dut_a, dut_b, dut_c, vec_idx, busy, done, pass, err_count, fail_valid, fail_vec
  );
  modport slave (
    input  start, dut_x, dut_y,
    output dut_a, dut_b, dut_c, vec_idx, busy, done, pass, err_count, fail_valid, fail_vec
  );
`else
  modport master (
    output start, dut_x, dut_y,
    input  dut_a, dut_b, dut_c, vec_idx, busy, done, pass, err_count
  );
  modport slave (
    input  start, dut_x, dut_y,
    output dut_a, dut_b, dut_c, vec_idx, busy, done, pass, err_count
  );
`endif
endinterface

// File: rtl/truth_table_sequencer.sv
// Self-test controller: sweeps all 8 input vectors of a 3-in/2-out block and compares against EXP_X/EXP_Y.
// Define TT_FAIL_LOG_EN to record the index of the first mismatching vector (fail_valid/fail_vec).
`timescale 1ns/1ps
module truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXP_X         = 8'h96,
  parameter logic [7:0]  EXP_Y         = 8'hE8
) (
  input logic                     clk,
  input logic                     rst_n,
  truth_table_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] settle_cnt;
  logic [2:0] vec_idx;
  logic [3:0] err_count;
  logic       pass_q;
  logic       accept;
  logic       mismatch;

  // NOTE: every signal driven in always_comb gets a default first so no latch can be inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mismatch   = (bus.dut_x != EXP_X[vec_idx]) || (bus.dut_y != EXP_Y[vec_idx]);
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = S_APPLY;
        end
      end
      S_APPLY:  state_next = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
      S_SETTLE: if (settle_cnt == SETTLE_LAST) state_next = S_CHECK;
      S_CHECK:  state_next = (vec_idx == 3'd7) ? S_DONE : S_APPLY;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= 4'd0;
      vec_idx    <= 3'd0;
      err_count  <= 4'd0;
      pass_q     <= 1'b0;
    end else begin
      if (state == S_APPLY)       settle_cnt <= 4'd0;
      else if (state == S_SETTLE) settle_cnt <= settle_cnt + 4'd1;

      if (accept) begin
        vec_idx   <= 3'd0;
        err_count <= 4'd0;
        pass_q    <= 1'b0;
      end else if (state == S_CHECK) begin
        // At most 8 increments per run, so the 4-bit count cannot wrap.
        if (mismatch) err_count <= err_count + 4'd1;
        if (vec_idx == 3'd7) begin
          vec_idx <= 3'd0;
          pass_q  <= (err_count == 4'd0) && !mismatch;
        end else begin
          vec_idx <= vec_idx + 3'd1;
        end
      end
    end
  end

`ifdef TT_FAIL_LOG_EN
  logic       fail_valid_q;
  logic [2:0] fail_vec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 3'd0;
    end else if (accept) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 3'd0;
    end else if (state == S_CHECK && mismatch && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_vec_q   <= vec_idx;
    end
  end

  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;
`endif

  assign bus.dut_a     = vec_idx[2];
  assign bus.dut_b     = vec_idx[1];
  assign bus.dut_c     = vec_idx[0];
  assign bus.vec_idx   = vec_idx;
  assign bus.busy      = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
  assign bus.done      = (state == S_DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count;

endmodule
